// File: rtl/guess_entry_if.sv
// guess_entry_if
//  Bundles the player/scorer inputs and the guess-entry outputs of guess_entry.
//  master : the driving side (button front end, scorer, bench)
//  slave  : guess_entry itself
//  Inputs  : mode, btn_left, btn_right, btn_up, btn_down, btn_select, game_over
//  Outputs : guess3..guess0, cursor, commit, reject, turn, last_turn, locked
interface guess_entry_if;
  logic       mode;
  logic       btn_left;
  logic       btn_right;
  logic       btn_up;
  logic       btn_down;
  logic       btn_select;
  logic       game_over;
  logic [2:0] guess3;
  logic [2:0] guess2;
  logic [2:0] guess1;
  logic [2:0] guess0;
  logic [1:0] cursor;
  logic       commit;
  logic       reject;
  logic [3:0] turn;
  logic       last_turn;
  logic       locked;

  modport master (
    output mode, btn_left, btn_right, btn_up, btn_down, btn_select, game_over,
    input  guess3, guess2, guess1, guess0, cursor, commit, reject, turn,
           last_turn, locked
  );

  modport slave (
    input  mode, btn_left, btn_right, btn_up, btn_down, btn_select, game_over,
    output guess3, guess2, guess1, guess0, cursor, commit, reject, turn,
           last_turn, locked
  );
endinterface

// File: rtl/guess_entry.sv
// guess_entry
//  Code-entry stage for the Mastermind game. Converts debounced button levels
//  into a 4-slot guess, pulses commit for one cycle when a guess is accepted,
//  counts turns and locks entry when the turn budget is spent or the game ends.
//  Ports:
//    clk    : clock
//    reset  : synchronous, active-high reset
//    bus    : guess_entry_if.slave (buttons, mode, game_over in; guess,
//             cursor, commit, reject, turn, last_turn, locked out)
//  Parameters: NUM_COLORS (2..8), MAX_TURNS (1..15)
//  Optional feature: define GUESS_DUP_CHECK_EN to refuse guesses containing
//  a repeated colour (reject pulse instead of commit).
//
//  state  | meaning
//  ENTRY  | buttons edit the guess and commit it (when mode == 0)
//  LOCKED | turn budget spent or game over; only reset leaves
module guess_entry #(
  parameter int NUM_COLORS = 6,
  parameter int MAX_TURNS  = 8
) (
  input logic         clk,
  input logic         reset,
  guess_entry_if.slave bus
);
  typedef enum logic {ENTRY = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [2:0] MAX_COLOR  = 3'(NUM_COLORS - 1);
  localparam logic [3:0] TURN_LIMIT = 4'(MAX_TURNS);
  localparam logic [3:0] TURN_LAST  = 4'(MAX_TURNS - 1);

  // button vector order: {select, left, right, up, down}
  logic [4:0]      btn_now, btn_q, btn_edge;
  state_t          state_q, state_d;
  logic [3:0][2:0] guess_q, guess_d;
  logic [1:0]      cursor_q, cursor_d;
  logic [3:0]      turn_q, turn_d;
  logic            commit_q, commit_d;
  logic            reject_q, reject_d;
  logic            last_turn_q, last_turn_d;
  logic            locked_q, locked_d;
  logic [2:0]      cur_val;
  logic            has_dup;

  assign btn_now  = {bus.btn_select, bus.btn_left, bus.btn_right, bus.btn_up, bus.btn_down};
  assign btn_edge = btn_now & ~btn_q;
  assign cur_val  = guess_q[cursor_q];
  assign has_dup  = (guess_q[3] == guess_q[2]) || (guess_q[3] == guess_q[1]) ||
                    (guess_q[3] == guess_q[0]) || (guess_q[2] == guess_q[1]) ||
                    (guess_q[2] == guess_q[0]) || (guess_q[1] == guess_q[0]);

  // State register. Edge-detect flops reset to 1 so a button held through
  // reset is not seen as a fresh press, and they track in every state/mode.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_q       <= '1;
      state_q     <= ENTRY;
      guess_q     <= '0;
      cursor_q    <= 2'd3;
      turn_q      <= '0;
      commit_q    <= 1'b0;
      reject_q    <= 1'b0;
      last_turn_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      btn_q       <= btn_now;
      state_q     <= state_d;
      guess_q     <= guess_d;
      cursor_q    <= cursor_d;
      turn_q      <= turn_d;
      commit_q    <= commit_d;
      reject_q    <= reject_d;
      last_turn_q <= last_turn_d;
      locked_q    <= locked_d;
    end
  end

  // Next-state logic: one action per cycle, select > left > right > up > down.
  always_comb begin
    state_d  = state_q;
    guess_d  = guess_q;
    cursor_d = cursor_q;
    turn_d   = turn_q;
    commit_d = 1'b0;
    reject_d = 1'b0;
    if (state_q == ENTRY) begin
      if (bus.game_over) begin
        // game over wins over any same-cycle press
        state_d = LOCKED;
      end else if (!bus.mode) begin
        if (btn_edge[4]) begin
`ifdef GUESS_DUP_CHECK_EN
          if (has_dup) begin
            reject_d = 1'b1;
          end else begin
`endif
            commit_d = 1'b1;
            turn_d   = turn_q + 4'd1;
            cursor_d = 2'd3;
            if (turn_q + 4'd1 == TURN_LIMIT) state_d = LOCKED;
`ifdef GUESS_DUP_CHECK_EN
          end
`endif
        end else if (btn_edge[3]) begin
          cursor_d = cursor_q + 2'd1;
        end else if (btn_edge[2]) begin
          cursor_d = cursor_q - 2'd1;
        end else if (btn_edge[1]) begin
          guess_d[cursor_q] = (cur_val == MAX_COLOR) ? 3'd0 : cur_val + 3'd1;
        end else if (btn_edge[0]) begin
          guess_d[cursor_q] = (cur_val == 3'd0) ? MAX_COLOR : cur_val - 3'd1;
        end
      end
    end
    last_turn_d = (turn_d == TURN_LAST);
    locked_d    = (state_d == LOCKED);
  end

  // Output logic: all outputs come straight from registers.
  always_comb begin
    bus.guess3    = guess_q[3];
    bus.guess2    = guess_q[2];
    bus.guess1    = guess_q[1];
    bus.guess0    = guess_q[0];
    bus.cursor    = cursor_q;
    bus.commit    = commit_q;
    bus.turn      = turn_q;
    bus.last_turn = last_turn_q;
    bus.locked    = locked_q;
`ifdef GUESS_DUP_CHECK_EN
    bus.reject    = reject_q;
`else
    bus.reject    = 1'b0 & reject_q & has_dup;
`endif
  end
endmodule

// File: tb/tb_guess_entry.sv
module tb_guess_entry;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  localparam logic [4:0] B_SEL   = 5'b10000;
  localparam logic [4:0] B_LEFT  = 5'b01000;
  localparam logic [4:0] B_RIGHT = 5'b00100;
  localparam logic [4:0] B_UP    = 5'b00010;
  localparam logic [4:0] B_DOWN  = 5'b00001;

  guess_entry_if gif();

  guess_entry #(.NUM_COLORS(6), .MAX_TURNS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (gif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] m);
    gif.btn_select = m[4];
    gif.btn_left   = m[3];
    gif.btn_right  = m[2];
    gif.btn_up     = m[1];
    gif.btn_down   = m[0];
  endtask

  task automatic push(input logic [4:0] m);
    drive(m);
    tick();
  endtask

  task automatic rel();
    drive(5'b0);
    tick();
  endtask

  task automatic tap(input logic [4:0] m, input int n);
    for (int k = 0; k < n; k++) begin
      push(m);
      rel();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Builds guess {3,2,1,0}, leaving cursor at 2.
  task automatic set_distinct();
    tap(B_UP, 3);
    tap(B_LEFT, 1);
    tap(B_LEFT, 1);
    tap(B_UP, 1);
    tap(B_LEFT, 1);
    tap(B_UP, 2);
  endtask

  task automatic test_reset();
    gif.mode = 1'b0;
    gif.game_over = 1'b0;
    drive(5'b0);
    do_reset();
    n_checks++;
    if ({gif.guess3, gif.guess2, gif.guess1, gif.guess0} !== 12'd0) begin
      n_fail++; $display("FAIL reset_guess got %h want 000", {gif.guess3, gif.guess2, gif.guess1, gif.guess0});
    end
    n_checks++;
    if (gif.cursor !== 2'd3) begin n_fail++; $display("FAIL reset_cursor got %0d want 3", gif.cursor); end
    n_checks++;
    if ({gif.turn, gif.commit, gif.reject, gif.last_turn, gif.locked} !== 8'd0) begin
      n_fail++; $display("FAIL reset_flags got %b want 00000000", {gif.turn, gif.commit, gif.reject, gif.last_turn, gif.locked});
    end
  endtask

  task automatic test_value();
    tap(B_UP, 2);
    n_checks++;
    if (gif.guess3 !== 3'd2) begin n_fail++; $display("FAIL up_x2 got %0d want 2", gif.guess3); end
    n_checks++;
    if ({gif.guess2, gif.guess1, gif.guess0} !== 9'd0) begin n_fail++; $display("FAIL up_others got %h want 000", {gif.guess2, gif.guess1, gif.guess0}); end
    tap(B_DOWN, 3);
    n_checks++;
    if (gif.guess3 !== 3'd5) begin n_fail++; $display("FAIL down_wrap got %0d want 5", gif.guess3); end
  endtask

  task automatic test_cursor();
    tap(B_LEFT, 1);
    n_checks++;
    if (gif.cursor !== 2'd0) begin n_fail++; $display("FAIL left_wrap got %0d want 0", gif.cursor); end
    tap(B_RIGHT, 1);
    n_checks++;
    if (gif.cursor !== 2'd3) begin n_fail++; $display("FAIL right_wrap got %0d want 3", gif.cursor); end
    push(B_UP | B_LEFT);
    n_checks++;
    if ({gif.cursor, gif.guess3, gif.guess0} !== {2'd0, 3'd5, 3'd0}) begin
      n_fail++; $display("FAIL up_left_prio got cur=%0d g3=%0d g0=%0d want cur=0 g3=5 g0=0", gif.cursor, gif.guess3, gif.guess0);
    end
    rel();
    tap(B_DOWN, 1);
    n_checks++;
    if ({gif.guess3, gif.guess0} !== {3'd5, 3'd5}) begin
      n_fail++; $display("FAIL down_slot0 got g3=%0d g0=%0d want g3=5 g0=5", gif.guess3, gif.guess0);
    end
    tap(B_RIGHT, 1);
    tap(B_UP, 1);
    n_checks++;
    if (gif.guess3 !== 3'd0) begin n_fail++; $display("FAIL up_wrap got %0d want 0", gif.guess3); end
  endtask

  task automatic test_held_select();
    drive(B_SEL);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if ({gif.commit, gif.turn} !== 5'd0) begin
        n_fail++; $display("FAIL held_select got commit=%b turn=%0d want commit=0 turn=0", gif.commit, gif.turn);
      end
    end
    rel();
`ifdef GUESS_DUP_CHECK_EN
    set_distinct();
`endif
    push(B_SEL);
    n_checks++;
    if ({gif.commit, gif.turn} !== {1'b1, 4'd1}) begin
      n_fail++; $display("FAIL first_commit got commit=%b turn=%0d want commit=1 turn=1", gif.commit, gif.turn);
    end
    rel();
    n_checks++;
    if ({gif.commit, gif.cursor} !== {1'b0, 2'd3}) begin
      n_fail++; $display("FAIL commit_pulse got commit=%b cursor=%0d want commit=0 cursor=3", gif.commit, gif.cursor);
    end
  endtask

  task automatic test_turn_limit();
    do_reset();
    set_distinct();
    for (int i = 1; i <= 8; i++) begin
      push(B_SEL);
      n_checks++;
      if ({gif.commit, gif.turn, gif.last_turn, gif.locked, gif.guess3, gif.guess0} !==
          {1'b1, 4'(i), (i == 7), (i == 8), 3'd3, 3'd0}) begin
        n_fail++; $display("FAIL commit_%0d got commit=%b turn=%0d last=%b locked=%b g3=%0d g0=%0d", i,
                           gif.commit, gif.turn, gif.last_turn, gif.locked, gif.guess3, gif.guess0);
      end
      rel();
      n_checks++;
      if (gif.commit !== 1'b0) begin n_fail++; $display("FAIL commit_%0d_end got %b want 0", i, gif.commit); end
    end
    push(B_SEL);
    n_checks++;
    if ({gif.commit, gif.turn, gif.locked} !== {1'b0, 4'd8, 1'b1}) begin
      n_fail++; $display("FAIL ninth_select got commit=%b turn=%0d locked=%b want 0 8 1", gif.commit, gif.turn, gif.locked);
    end
    rel();
    tap(B_UP, 1);
    n_checks++;
    if (gif.guess3 !== 3'd3) begin n_fail++; $display("FAIL locked_up got %0d want 3", gif.guess3); end
  endtask

  task automatic test_mode();
    do_reset();
    gif.mode = 1'b1;
    tap(B_UP, 1);
    tap(B_SEL, 1);
    n_checks++;
    if ({gif.guess3, gif.turn, gif.commit} !== 8'd0) begin
      n_fail++; $display("FAIL mode_ignore got g3=%0d turn=%0d commit=%b want 0 0 0", gif.guess3, gif.turn, gif.commit);
    end
    push(B_UP);
    gif.mode = 1'b0;
    tick();
    tick();
    n_checks++;
    if (gif.guess3 !== 3'd0) begin n_fail++; $display("FAIL mode_release_held got %0d want 0", gif.guess3); end
    rel();
  endtask

  task automatic test_game_over();
    do_reset();
    set_distinct();
    gif.game_over = 1'b1;
    push(B_SEL);
    n_checks++;
    if ({gif.commit, gif.turn, gif.locked} !== {1'b0, 4'd0, 1'b1}) begin
      n_fail++; $display("FAIL game_over_select got commit=%b turn=%0d locked=%b want 0 0 1", gif.commit, gif.turn, gif.locked);
    end
    gif.game_over = 1'b0;
    rel();
    tap(B_UP, 1);
    n_checks++;
    if ({gif.guess3, gif.locked} !== {3'd3, 1'b1}) begin
      n_fail++; $display("FAIL game_over_hold got g3=%0d locked=%b want 3 1", gif.guess3, gif.locked);
    end
  endtask

  // Ends with select held and the accepted commit pulse high.
  task automatic test_dup();
    do_reset();
    tap(B_UP, 1);
    tap(B_LEFT, 1);
    tap(B_UP, 3);
    tap(B_LEFT, 1);
    tap(B_UP, 2);
    tap(B_LEFT, 1);
    tap(B_UP, 1);
    push(B_SEL);
`ifdef GUESS_DUP_CHECK_EN
    n_checks++;
    if ({gif.reject, gif.commit, gif.turn, gif.cursor} !== {1'b1, 1'b0, 4'd0, 2'd2}) begin
      n_fail++; $display("FAIL dup_reject got rej=%b commit=%b turn=%0d cur=%0d want 1 0 0 2", gif.reject, gif.commit, gif.turn, gif.cursor);
    end
    rel();
    n_checks++;
    if (gif.reject !== 1'b0) begin n_fail++; $display("FAIL dup_reject_pulse got %b want 0", gif.reject); end
    tap(B_DOWN, 1);
    push(B_SEL);
`endif
    n_checks++;
    if ({gif.commit, gif.reject, gif.turn, gif.cursor} !== {1'b1, 1'b0, 4'd1, 2'd3}) begin
      n_fail++; $display("FAIL dup_commit got commit=%b rej=%b turn=%0d cur=%0d want 1 0 1 3", gif.commit, gif.reject, gif.turn, gif.cursor);
    end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    tick();
    n_checks++;
    if ({gif.commit, gif.reject, gif.turn, gif.cursor, gif.guess3, gif.guess0} !== {1'b0, 1'b0, 4'd0, 2'd3, 3'd0, 3'd0}) begin
      n_fail++; $display("FAIL reset_mid got commit=%b rej=%b turn=%0d cur=%0d g3=%0d g0=%0d want 0 0 0 3 0 0",
                         gif.commit, gif.reject, gif.turn, gif.cursor, gif.guess3, gif.guess0);
    end
    reset = 1'b0;
    rel();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    test_reset();
    test_value();
    test_cursor();
    test_held_select();
    test_turn_limit();
    test_mode();
    test_game_over();
    test_dup();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
